// File: rtl/rom_reader.sv
// Burst reader: fetches a run of consecutive words from a registered-output ROM
// and presents them one at a time on a valid/ready stream.
module rom_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LATCH,
        OUT,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [ADDR_W:0]   rem, rem_next;
    logic [ADDR_W:0]   len_clamped;
    logic              out_valid_next;
    logic              out_last_next;
    logic [DATA_W-1:0] out_data_next;
    logic              handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            rem       <= rem_next;
            out_valid <= out_valid_next;
            out_last  <= out_last_next;
            out_data  <= out_data_next;
        end
    end

    // A burst longer than the ROM is clamped to one full pass over it.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        rem_next       = rem;
        out_valid_next = out_valid;
        out_last_next  = out_last;
        out_data_next  = out_data;
        len_clamped    = (length > DEPTH) ? DEPTH : length;
        handshake      = out_valid && out_ready;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    ptr_next   = base_addr;
                    rem_next   = len_clamped;
                    state_next = (len_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_next = LATCH;
            end
            LATCH: begin
                out_data_next  = rom_data;
                out_valid_next = 1'b1;
                out_last_next  = (rem == ONE);
                state_next     = OUT;
            end
            OUT: begin
                if (handshake) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    if (rem == ONE) begin
                        state_next = DONE;
                    end else begin
                        ptr_next   = ptr + 1'b1;
                        rem_next   = rem - ONE;
                        state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort drops whatever word is pending and skips the done pulse.
        if (abort && state != IDLE) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end
    end

    assign rom_en   = (state == ISSUE);
    assign rom_addr = ptr;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_rom_reader.sv
// Testbench for rom_reader: 16x4 registered ROM with mem[i] = ~i, a scoreboard
// of expected words/addresses, a table of bursts and hand-written corner cases.
module tb_rom_reader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    typedef struct {
        int base;
        int len;
        int words;
        int cycles;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [DEPTH];

    int checks = 0;
    int passes = 0;
    int rom_en_cnt = 0;
    int done_cnt = 0;
    int word_cnt = 0;
    int en0, w0, d0, cyc;

    word_t             exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    vec_t              vecs[7];

    always #5 clk = ~clk;

    rom_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .abort(abort),
        .rom_en(rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    // Registered ROM model: data appears the cycle after rom_en.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = ~4'(i);
    end

    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic reportFail(input string name);
        checks++;
        $display("[TB] FAIL %s: event seen/missing, expected otherwise", name);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin : monitor
        word_t w;
        if (rom_en === 1'b1) begin
            rom_en_cnt++;
            if (addr_q.size() > 0) checkOutput("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
            else reportFail("unexpected rom_en");
        end
        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            word_cnt++;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(w.data));
                checkOutput("out_last", 32'(out_last), 32'(w.last));
            end else begin
                reportFail("unexpected word");
            end
        end
    end

    // Drive a start pulse and push the expected burst into the scoreboard.
    task automatic applyStimulus(input int b, input int l);
        int n;
        logic [ADDR_W-1:0] a;
        n = (l > DEPTH) ? DEPTH : l;
        for (int i = 0; i < n; i++) begin
            a = 4'(b + i);
            addr_q.push_back(a);
            exp_q.push_back('{data: ~a, last: (i == n - 1)});
        end
        base_addr = 4'(b);
        length    = 5'(l);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int c);
        c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (done !== 1'b1) reportFail("done timeout");
    endtask

    task automatic waitValid(input int budget);
        int c;
        c = 0;
        while (out_valid !== 1'b1 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (out_valid !== 1'b1) reportFail("out_valid timeout");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{2, 3, 3, 9};
        vecs[1] = '{14, 4, 4, 12};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{5, 20, 16, 48};
        vecs[4] = '{15, 1, 1, 3};
        vecs[5] = '{7, 16, 16, 48};
        vecs[6] = '{9, 17, 16, 48};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; length = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rom_en", 32'(rom_en), 0);
        checkOutput("reset rom_addr", 32'(rom_addr), 0);
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset out_last", 32'(out_last), 0);
        checkOutput("reset out_data", 32'(out_data), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);

        // Latency: start right after reset release, rom_en at 1, out_valid at 3.
        rst = 1'b0;
        applyStimulus(2, 3);
        checkOutput("lat rom_en c1", 32'(rom_en), 1);
        checkOutput("lat rom_addr c1", 32'(rom_addr), 2);
        checkOutput("lat busy c1", 32'(busy), 1);
        @(posedge clk); #1;
        checkOutput("lat rom_en c2", 32'(rom_en), 0);
        checkOutput("lat out_valid c2", 32'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("lat out_valid c3", 32'(out_valid), 1);
        checkOutput("lat out_data c3", 32'(out_data), 32'h0D);
        checkOutput("lat out_last c3", 32'(out_last), 0);
        waitDone(100, cyc);
        checkOutput("lat done cycle", 32'(cyc), 7);
        @(posedge clk); #1;
        checkOutput("lat done width", 32'(done), 0);

        // Table of bursts with out_ready held high.
        foreach (vecs[i]) begin
            en0 = rom_en_cnt; w0 = word_cnt; d0 = done_cnt;
            applyStimulus(vecs[i].base, vecs[i].len);
            waitDone(200, cyc);
            checkOutput("vec cycles", 32'(cyc), 32'(vecs[i].cycles));
            @(posedge clk); #1;
            checkOutput("vec done width", 32'(done), 0);
            checkOutput("vec busy after", 32'(busy), 0);
            checkOutput("vec words", 32'(word_cnt - w0), 32'(vecs[i].words));
            checkOutput("vec rom_en count", 32'(rom_en_cnt - en0), 32'(vecs[i].words));
            checkOutput("vec done count", 32'(done_cnt - d0), 1);
            checkOutput("vec queue empty", 32'(exp_q.size()), 0);
        end

        // Backpressure on word 1: output holds, no new fetch.
        out_ready = 1'b0;
        w0 = word_cnt;
        applyStimulus(4, 2);
        waitValid(20);
        en0 = rom_en_cnt;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp out_valid", 32'(out_valid), 1);
            checkOutput("bp out_data", 32'(out_data), 32'h0B);
            @(posedge clk); #1;
        end
        checkOutput("bp no rom_en", 32'(rom_en_cnt - en0), 0);
        out_ready = 1'b1;
        waitDone(50, cyc);
        checkOutput("bp rom_en after", 32'(rom_en_cnt - en0), 1);
        checkOutput("bp words", 32'(word_cnt - w0), 2);
        @(posedge clk); #1;

        // Abort during OUT of word 2 of 4.
        out_ready = 1'b0;
        d0 = done_cnt; w0 = word_cnt;
        applyStimulus(0, 4);
        waitValid(20);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        waitValid(20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        addr_q.delete();
        checkOutput("abort busy", 32'(busy), 0);
        checkOutput("abort out_valid", 32'(out_valid), 0);
        checkOutput("abort out_last", 32'(out_last), 0);
        en0 = rom_en_cnt;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort no done", 32'(done_cnt - d0), 0);
        checkOutput("abort no rom_en", 32'(rom_en_cnt - en0), 0);
        checkOutput("abort words", 32'(word_cnt - w0), 1);

        // Same scenario with rst, then an immediate restart.
        out_ready = 1'b1;
        applyStimulus(10, 4);
        waitValid(20);
        @(posedge clk); #1;
        out_ready = 1'b0;
        waitValid(20);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        addr_q.delete();
        checkOutput("rst rom_en", 32'(rom_en), 0);
        checkOutput("rst rom_addr", 32'(rom_addr), 0);
        checkOutput("rst out_valid", 32'(out_valid), 0);
        checkOutput("rst out_last", 32'(out_last), 0);
        checkOutput("rst out_data", 32'(out_data), 0);
        checkOutput("rst busy", 32'(busy), 0);
        checkOutput("rst done", 32'(done), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        w0 = word_cnt;
        applyStimulus(3, 2);
        checkOutput("rst restart rom_en", 32'(rom_en), 1);
        waitDone(50, cyc);
        checkOutput("rst restart words", 32'(word_cnt - w0), 2);
        @(posedge clk); #1;

        // Second start mid-burst is ignored.
        w0 = word_cnt; en0 = rom_en_cnt;
        applyStimulus(6, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        base_addr = 4'd1; length = 5'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(100, cyc);
        @(posedge clk); #1;
        checkOutput("busy-start words", 32'(word_cnt - w0), 3);
        checkOutput("busy-start rom_en", 32'(rom_en_cnt - en0), 3);
        checkOutput("busy-start queue", 32'(exp_q.size()), 0);

        // Abort together with start in IDLE: nothing starts.
        en0 = rom_en_cnt; d0 = done_cnt;
        base_addr = 4'd0; length = 5'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checkOutput("abort+start busy", 32'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort+start rom_en", 32'(rom_en_cnt - en0), 0);
        checkOutput("abort+start done", 32'(done_cnt - d0), 0);

        checkOutput("final queue empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
